// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, data width, default bit timing
// and the parity helper used by both link directions.
package uart_pkg;

  localparam int UART_DATA_W           = 8;
  localparam int UART_CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Even-parity bit for a data byte: XOR of all data bits.
  function automatic logic uart_parity(input logic [UART_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops load RST_VAL on reset so the output starts at a known level.
module uart_sync2 #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled start/data/stop recovery into a valid/ack holding register.
// Defining UART_RX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter bit RX_IDLE      = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_in,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ack,
  output logic                   rx_busy,
  output logic                   rx_frame_err,
  output logic                   rx_overrun,
  output logic                   rx_parity_err
);

  localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [1:0]             fill_q;
  logic                   armed_q;
  logic                   line;
  logic                   stop_term;
  logic                   stop_ok;
  logic                   deliver;

  logic [UART_DATA_W-1:0] data_q;
  logic                   valid_q;
  logic                   frame_err_q;
  logic                   overrun_q;

  uart_sync2 #(.RST_VAL(RX_IDLE)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_in),
    .q_o (line)
  );

  // fill_q marks when the synchronizer holds real samples rather than its
  // reset value, so a line stuck at start level out of reset never arms.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      fill_q  <= {fill_q[0], 1'b1};
      if (fill_q[1] && (line == RX_IDLE)) begin
        armed_q <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    stop_term = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (armed_q && (line != RX_IDLE)) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_TC) begin
          cnt_d = '0;
          if (line != RX_IDLE) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_TC) begin
          cnt_d          = '0;
          shift_d[idx_q] = line;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_TC) begin
          cnt_d     = '0;
          par_bad_d = line ^ uart_parity(shift_q);
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        // Return to IDLE at mid-stop so the next start edge is never missed.
        if (cnt_q == FULL_TC) begin
          cnt_d     = '0;
          stop_term = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign stop_ok = (line == RX_IDLE);
  assign deliver = stop_term && stop_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_term && !stop_ok;
      overrun_q   <= 1'b0;
      if (deliver) begin
        // An ack in the delivery cycle frees the holding register for the new byte.
        if (!valid_q || rx_ack) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && rx_ack) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= deliver && par_bad_q;
    end
  end

  assign rx_parity_err = parity_err_q;
`else
  assign rx_parity_err = 1'b0;
`endif

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_busy      = (state_q != IDLE);
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: stimulus pushes expected events, a monitor pops them.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_receiver;

  localparam int CPB = 16;
  localparam bit RXI = 1'b1;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NB  = PAR_EN ? 11 : 10;
  localparam int LAT = 2 + CPB / 2 + (NB - 1) * CPB;

  localparam int K_BYTE = 0;
  localparam int K_FERR = 1;
  localparam int K_OVR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       perr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = RXI;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_busy;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_parity_err;

  logic auto_ack   = 1'b1;
  logic manual_ack = 1'b0;
  logic par_flip   = 1'b0;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  assign rx_ack = auto_ack ? rx_valid : manual_ack;

  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(CPB), .RX_IDLE(RXI)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_in         (rx_in),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ack        (rx_ack),
    .rx_busy       (rx_busy),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun),
    .rx_parity_err (rx_parity_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] d, input logic perr);
    exp_t e;
    e.kind = kind;
    e.data = d;
    e.perr = perr;
    exp_q.push_back(e);
  endtask

  task automatic got_event(input int kind, input logic [7:0] d, input logic perr);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data %02h, expected no event", kind, d);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.data !== d || e.perr !== perr) begin
      n_fail++;
      $display("FAIL event: got kind %0d data %02h perr %0b, expected kind %0d data %02h perr %0b",
               kind, d, perr, e.kind, e.data, e.perr);
    end
  endtask

  // Drives the first nbits of a frame, one bit per CPB clocks, starting #1 after a posedge.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int nbits);
    logic [10:0] fr;
    fr    = '1;
    fr[0] = ~RXI;
    for (int i = 0; i < 8; i++) fr[1+i] = d[i];
`ifdef UART_RX_PARITY_EN
    fr[9]  = (^d) ^ par_flip;
    fr[10] = stop_b;
`else
    fr[9]  = stop_b;
`endif
    for (int i = 0; i < nbits; i++) begin
      rx_in = fr[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx_in = RXI;
  endtask

  task automatic issue_frame(input logic [7:0] d, input logic stop_b);
    if (stop_b == RXI) push(K_BYTE, d, PAR_EN & par_flip);
    else               push(K_FERR, 8'h00, 1'b0);
    send_frame(d, stop_b, NB);
  endtask

  task automatic idle(input int n);
    rx_in = RXI;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: a byte is presented when valid rises, or valid stays high across an accepted handshake.
  initial begin
    logic pv, pa;
    pv = 1'b0;
    pa = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        pa = 1'b0;
      end else begin
        if (rx_valid && (!pv || pa)) got_event(K_BYTE, rx_data, rx_parity_err);
        else if (rx_parity_err)     got_event(K_BYTE, 8'hxx, 1'b1);
        if (rx_frame_err) got_event(K_FERR, 8'h00, 1'b0);
        if (rx_overrun)   got_event(K_OVR, rx_data, 1'b0);
        pv = rx_valid;
        pa = rx_ack;
      end
    end
  end

  initial begin
    int n;
    logic [7:0] d;
    logic       sb;

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 8'h00);
    check("reset_busy", rx_busy, 0);
    check("reset_ferr", rx_frame_err, 0);
    check("reset_ovr", rx_overrun, 0);
    check("reset_perr", rx_parity_err, 0);
    rst = 1'b0;
    idle(4);

    // Nominal byte with latency measurement.
    push(K_BYTE, 8'hA5, 1'b0);
    n = 0;
    fork
      send_frame(8'hA5, RXI, NB);
      begin
        while (n < 400) begin
          @(posedge clk);
          #1;
          n++;
          if (rx_valid) break;
        end
      end
    join
    check("latency", n - 1, LAT);
    idle(CPB);

    // Short low glitch on an idle line.
    rx_in = ~RXI;
    repeat (4) @(posedge clk);
    #1;
    rx_in = RXI;
    check("glitch_busy_hi", rx_busy, 1);
    idle(3 * CPB);
    check("glitch_busy_lo", rx_busy, 0);

    // Bad stop bit, then recovery.
    issue_frame(8'h3C, ~RXI);
    idle(2 * CPB);
    check("ferr_no_valid", rx_valid, 0);
    issue_frame(8'h11, RXI);
    idle(2 * CPB);

    // Back-to-back with no ack: second byte dropped.
    auto_ack = 1'b0;
    push(K_BYTE, 8'h00, 1'b0);
    push(K_OVR, 8'h00, 1'b0);
    send_frame(8'h00, RXI, NB);
    send_frame(8'hFF, RXI, NB);
    idle(CPB);
    check("ovr_data_kept", rx_data, 8'h00);
    manual_ack = 1'b1;
    idle(1);
    manual_ack = 1'b0;
    idle(2);
    check("ovr_cleared", rx_valid, 0);

    // Back-to-back with ack in the delivery cycle of the second byte.
    push(K_BYTE, 8'h00, 1'b0);
    push(K_BYTE, 8'hFF, 1'b0);
    fork
      begin
        send_frame(8'h00, RXI, NB);
        send_frame(8'hFF, RXI, NB);
      end
      begin
        repeat (NB * CPB + LAT) @(posedge clk);
        #1;
        manual_ack = 1'b1;
        @(posedge clk);
        #1;
        manual_ack = 1'b0;
      end
    join
    check("ack_dlv_data", rx_data, 8'hFF);
    check("ack_dlv_valid", rx_valid, 1);
    manual_ack = 1'b1;
    idle(1);
    manual_ack = 1'b0;
    auto_ack   = 1'b1;
    idle(CPB);

    // Reset mid-DATA with the line held at start level afterwards.
    send_frame(8'h5A, RXI, 5);
    rx_in = ~RXI;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1;
    check("rst_busy", rx_busy, 0);
    check("rst_valid", rx_valid, 0);
    idle(2 * CPB);
    issue_frame(8'h81, RXI);
    idle(2 * CPB);

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
    issue_frame(8'h07, RXI);
    idle(CPB);
    par_flip = 1'b0;
    issue_frame(8'h07, RXI);
    idle(CPB);
`endif

    // Randomized traffic with occasional framing errors and minimal gaps.
    for (int i = 0; i < 24; i++) begin
      d        = 8'($urandom_range(0, 255));
      sb       = ($urandom_range(0, 5) == 0) ? ~RXI : RXI;
      par_flip = PAR_EN && ($urandom_range(0, 3) == 0);
      issue_frame(d, sb);
      if (sb == RXI) idle($urandom_range(0, 3));
      else           idle(2 * CPB + $urandom_range(0, 5));
    end
    par_flip = 1'b0;
    idle(4 * CPB);
    check("final_busy", rx_busy, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
